// File: rtl/axi4l_reg_slave.sv
// axi4l_reg_slave: AXI4-Lite slave exposing four DW-bit registers.
// Define AXI4L_SLAVE_WAIT_EN to hold each ready off for WAIT_CYCLES.
module axi4l_reg_slave #(
  parameter int DW          = 32,
  parameter int AW          = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            s00_axi_aclk,
  input  logic            s00_axi_areset,
  input  logic [AW-1:0]   s00_axi_awaddr,
  input  logic [2:0]      s00_axi_awprot,
  input  logic            s00_axi_awvalid,
  output logic            s00_axi_awready,
  input  logic [DW-1:0]   s00_axi_wdata,
  input  logic [DW/8-1:0] s00_axi_wstrb,
  input  logic            s00_axi_wvalid,
  output logic            s00_axi_wready,
  output logic [1:0]      s00_axi_bresp,
  output logic            s00_axi_bvalid,
  input  logic            s00_axi_bready,
  input  logic [AW-1:0]   s00_axi_araddr,
  input  logic [2:0]      s00_axi_arprot,
  input  logic            s00_axi_arvalid,
  output logic            s00_axi_arready,
  output logic [DW-1:0]   s00_axi_rdata,
  output logic [1:0]      s00_axi_rresp,
  output logic            s00_axi_rvalid,
  input  logic            s00_axi_rready
);
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DW-1:0]   r_regs [4];
  logic            r_en;
  logic            r_aw_done;
  logic            r_w_done;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic [0:0]      r_rstate;
  logic [DW-1:0]   r_rdata;
  logic [1:0]      r_rresp;

  logic            w_aw_ok;
  logic            w_w_ok;
  logic            w_ar_ok;
  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_ar_hs;
  logic            w_commit;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wd;
  logic [DW/8-1:0] w_ws;
  logic [5:0]      w_unused_prot;
  logic [31:0]     w_unused_wait;

  assign w_unused_prot = {s00_axi_awprot, s00_axi_arprot};
  assign w_unused_wait = WAIT_CYCLES;

`ifdef AXI4L_SLAVE_WAIT_EN
  localparam logic [7:0] WC = 8'(WAIT_CYCLES);
  logic [7:0] r_aw_cnt;
  logic [7:0] r_w_cnt;
  logic [7:0] r_ar_cnt;

  // Counts consecutive valid cycles, saturating once the wait is met
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_aw_cnt <= '0;
      r_w_cnt  <= '0;
      r_ar_cnt <= '0;
    end else begin
      r_aw_cnt <= (!s00_axi_awvalid || w_aw_hs) ? 8'd0 :
                  (r_aw_cnt < WC) ? r_aw_cnt + 8'd1 : r_aw_cnt;
      r_w_cnt  <= (!s00_axi_wvalid || w_w_hs) ? 8'd0 :
                  (r_w_cnt < WC) ? r_w_cnt + 8'd1 : r_w_cnt;
      r_ar_cnt <= (!s00_axi_arvalid || w_ar_hs) ? 8'd0 :
                  (r_ar_cnt < WC) ? r_ar_cnt + 8'd1 : r_ar_cnt;
    end
  end

  assign w_aw_ok = (r_aw_cnt >= WC);
  assign w_w_ok  = (r_w_cnt >= WC);
  assign w_ar_ok = (r_ar_cnt >= WC);
`else
  assign w_aw_ok = 1'b1;
  assign w_w_ok  = 1'b1;
  assign w_ar_ok = 1'b1;
`endif

  assign s00_axi_awready = r_en && !r_aw_done && !r_bvalid && w_aw_ok;
  assign s00_axi_wready  = r_en && !r_w_done && !r_bvalid && w_w_ok;
  assign s00_axi_arready = r_en && (r_rstate == R_IDLE) && w_ar_ok;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_rvalid  = (r_rstate == R_DATA);
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = r_rresp;

  assign w_aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_w_hs  = s00_axi_wvalid && s00_axi_wready;
  assign w_ar_hs = s00_axi_arvalid && s00_axi_arready;

  // The second half to arrive commits on its own handshake edge
  assign w_waddr  = r_aw_done ? r_awaddr : s00_axi_awaddr;
  assign w_wd     = r_w_done ? r_wdata : s00_axi_wdata;
  assign w_ws     = r_w_done ? r_wstrb : s00_axi_wstrb;
  assign w_commit = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_en      <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_commit) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_waddr[1:0] != 2'b00) begin
          r_bresp <= 2'b10;
        end else begin
          r_bresp <= 2'b00;
          for (int b = 0; b < DW/8; b++)
            if (w_ws[b])
              r_regs[w_waddr[AW-1:2]][8*b +: 8] <= w_wd[8*b +: 8];
        end
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
          r_awaddr  <= s00_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_done <= 1'b1;
          r_wdata  <= s00_axi_wdata;
          r_wstrb  <= s00_axi_wstrb;
        end
        if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
      end
    end
  end

  // Registers are sampled before any same-edge commit lands
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate <= R_DATA;
            if (s00_axi_araddr[1:0] != 2'b00) begin
              r_rdata <= '0;
              r_rresp <= 2'b10;
            end else begin
              r_rdata <= r_regs[s00_axi_araddr[AW-1:2]];
              r_rresp <= 2'b00;
            end
          end
        end
        R_DATA: begin
          if (s00_axi_rready) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end
endmodule
